// File: rtl/mem_access.sv
// Memory stage: passes ALU results to writeback, or runs one data-memory
// load/store over a req/gnt/rvalid handshake while holding the pipeline.
module mem_access #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11,
    parameter int REG_W  = 5
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [DATA_W-1:0] st_data_i,
    input  logic              mem_en_i,
    input  logic              mem_wr_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [REG_W-1:0]  wbAddr_i,
    input  logic              wbEnable_i,
    input  logic              displayEn_i,
    output logic              stall_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic [DATA_W-1:0] wb_data_o,
    output logic [REG_W-1:0]  wbAddr_o,
    output logic              wbEnable_o,
    output logic [DATA_W-1:0] disp_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [REG_W-1:0]   hold_wba_q, hold_wba_d;
    logic               hold_wbe_q, hold_wbe_d;
    logic [DATA_W-1:0]  wb_data_q, wb_data_d;
    logic [REG_W-1:0]   wb_addr_q, wb_addr_d;
    logic               wb_en_q, wb_en_d;
    logic [DATA_W-1:0]  disp_q, disp_d;
    logic               done_s;
    logic               stall_s;

    // State and output registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= {ADDR_W{1'b0}};
            wdata_q    <= {DATA_W{1'b0}};
            hold_wba_q <= {REG_W{1'b0}};
            hold_wbe_q <= 1'b0;
            wb_data_q  <= {DATA_W{1'b0}};
            wb_addr_q  <= {REG_W{1'b0}};
            wb_en_q    <= 1'b0;
            disp_q     <= {DATA_W{1'b0}};
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            hold_wba_q <= hold_wba_d;
            hold_wbe_q <= hold_wbe_d;
            wb_data_q  <= wb_data_d;
            wb_addr_q  <= wb_addr_d;
            wb_en_q    <= wb_en_d;
            disp_q     <= disp_d;
        end
    end

    // Next-state, handshake and writeback selection
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        hold_wba_d = hold_wba_q;
        hold_wbe_d = hold_wbe_q;
        wb_data_d  = wb_data_q;
        wb_addr_d  = wb_addr_q;
        wb_en_d    = 1'b0;
        done_s     = 1'b0;
        stall_s    = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_en_i) begin
                    req_d      = 1'b1;
                    we_d       = mem_wr_i;
                    addr_d     = mem_addr_i;
                    wdata_d    = st_data_i;
                    hold_wba_d = wbAddr_i;
                    hold_wbe_d = wbEnable_i;
                    state_d    = REQ;
                    stall_s    = 1'b1;
                end else begin
                    wb_data_d = data_i;
                    wb_addr_d = wbAddr_i;
                    wb_en_d   = wbEnable_i & (wbAddr_i != {REG_W{1'b0}});
                end
            end
            REQ: begin
                if (dmem_gnt_i) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        done_s  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = RESP;
                    end
                end else begin
                    req_d = 1'b1;
                end
                stall_s = ~done_s;
            end
            RESP: begin
                // rvalid only counts here; earlier pulses are not ours
                if (dmem_rvalid_i) begin
                    done_s    = 1'b1;
                    state_d   = IDLE;
                    wb_data_d = dmem_rdata_i;
                    wb_addr_d = hold_wba_q;
                    wb_en_d   = hold_wbe_q & (hold_wba_q != {REG_W{1'b0}});
                end else begin
                    state_d = RESP;
                end
                stall_s = ~done_s;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        if (displayEn_i && !stall_s) begin
            disp_d = data_i;
        end else begin
            disp_d = disp_q;
        end
    end

    assign stall_o      = stall_s;
    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign wb_data_o    = wb_data_q;
    assign wbAddr_o     = wb_addr_q;
    assign wbEnable_o   = wb_en_q;
    assign disp_o       = disp_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access; writeback events are scoreboarded.
module tb_mem_access;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] data_i, st_data_i;
    logic        mem_en_i, mem_wr_i;
    logic [10:0] mem_addr_i;
    logic [4:0]  wbAddr_i;
    logic        wbEnable_i, displayEn_i;
    logic        stall_o, dmem_req_o, dmem_we_o;
    logic [10:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic [31:0] wb_data_o;
    logic [4:0]  wbAddr_o;
    logic        wbEnable_o;
    logic [31:0] disp_o;

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  a;
    } wb_t;

    wb_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    always #5 clk_i = ~clk_i;

    mem_access dut (
        .clk_i(clk_i), .reset_i(reset_i), .data_i(data_i), .st_data_i(st_data_i),
        .mem_en_i(mem_en_i), .mem_wr_i(mem_wr_i), .mem_addr_i(mem_addr_i),
        .wbAddr_i(wbAddr_i), .wbEnable_i(wbEnable_i), .displayEn_i(displayEn_i),
        .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i(dmem_rdata_i), .wb_data_o(wb_data_o), .wbAddr_o(wbAddr_o),
        .wbEnable_o(wbEnable_o), .disp_o(disp_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        data_i = 32'd0; st_data_i = 32'd0; mem_en_i = 1'b0; mem_wr_i = 1'b0;
        mem_addr_i = 11'd0; wbAddr_i = 5'd0; wbEnable_i = 1'b0; displayEn_i = 1'b0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'd0;
    endtask

    task automatic alu(input logic [31:0] d, input logic [4:0] a, input logic e);
        idle_inputs();
        data_i = d; wbAddr_i = a; wbEnable_i = e;
        if (e && a != 5'd0) exp_q.push_back('{d: d, a: a});
    endtask

    task automatic mem(input logic wr, input logic [10:0] addr, input logic [31:0] sd,
                       input logic [4:0] a, input logic e);
        idle_inputs();
        mem_en_i = 1'b1; mem_wr_i = wr; mem_addr_i = addr; st_data_i = sd;
        wbAddr_i = a; wbEnable_i = e;
    endtask

    // Writeback monitor: every strobe must match the oldest expected entry
    always @(negedge clk_i) begin
        if (wbEnable_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wb", 32'(wbAddr_o), 32'hFFFF_FFFF);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                chk("wb_data", wb_data_o, e.d);
                chk("wb_addr", 32'(wbAddr_o), 32'(e.a));
            end
        end
    end

    initial begin
        idle_inputs();
        reset_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("rst_req", 32'(dmem_req_o), 32'd0);
        chk("rst_we", 32'(dmem_we_o), 32'd0);
        chk("rst_addr", 32'(dmem_addr_o), 32'd0);
        chk("rst_wdata", dmem_wdata_o, 32'd0);
        chk("rst_wbdata", wb_data_o, 32'd0);
        chk("rst_wbaddr", 32'(wbAddr_o), 32'd0);
        chk("rst_wben", 32'(wbEnable_o), 32'd0);
        chk("rst_disp", disp_o, 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        reset_i = 1'b0;
        @(negedge clk_i);

        // ALU pass-through, then x0 suppression, then a short random burst
        alu(32'h0000_1234, 5'd5, 1'b1);
        #1 chk("alu_stall", 32'(stall_o), 32'd0);
        @(negedge clk_i);
        alu(32'h0000_FFFF, 5'd0, 1'b1);
        @(negedge clk_i);
        chk("x0_wben", 32'(wbEnable_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            alu($urandom, 5'($urandom_range(1, 31)), 1'b1);
            @(negedge clk_i);
        end
        idle_inputs();
        @(negedge clk_i);

        // Load with gnt delayed, stray rvalid in REQ, rvalid two cycles after gnt
        mem(1'b0, 11'h7FF, 32'h0, 5'd9, 1'b1);
        exp_q.push_back('{d: 32'hDEAD_BEEF, a: 5'd9});
        #1 chk("ld_accept_stall", 32'(stall_o), 32'd1);
        @(negedge clk_i);
        idle_inputs();
        #1;
        chk("ld_req", 32'(dmem_req_o), 32'd1);
        chk("ld_we", 32'(dmem_we_o), 32'd0);
        chk("ld_addr", 32'(dmem_addr_o), 32'h7FF);
        chk("ld_req_stall", 32'(stall_o), 32'd1);
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h0BAD_F00D;
        #1 chk("ld_stray_rvalid_stall", 32'(stall_o), 32'd1);
        @(negedge clk_i);
        dmem_rvalid_i = 1'b0;
        chk("ld_req_held", 32'(dmem_req_o), 32'd1);
        chk("ld_addr_held", 32'(dmem_addr_o), 32'h7FF);
        @(negedge clk_i);
        dmem_gnt_i = 1'b1;
        #1 chk("ld_gnt_stall", 32'(stall_o), 32'd1);
        @(negedge clk_i);
        dmem_gnt_i = 1'b0;
        #1;
        chk("ld_req_drop", 32'(dmem_req_o), 32'd0);
        chk("ld_resp_stall", 32'(stall_o), 32'd1);
        @(negedge clk_i);
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
        #1 chk("ld_rvalid_stall", 32'(stall_o), 32'd0);
        @(negedge clk_i);
        dmem_rvalid_i = 1'b0;
        @(negedge clk_i);

        // Store with gnt in the first request cycle; no writeback allowed
        mem(1'b1, 11'h010, 32'hA5A5_A5A5, 5'd3, 1'b1);
        #1 chk("st_accept_stall", 32'(stall_o), 32'd1);
        @(negedge clk_i);
        idle_inputs();
        dmem_gnt_i = 1'b1;
        #1;
        chk("st_req", 32'(dmem_req_o), 32'd1);
        chk("st_we", 32'(dmem_we_o), 32'd1);
        chk("st_addr", 32'(dmem_addr_o), 32'h010);
        chk("st_wdata", dmem_wdata_o, 32'hA5A5_A5A5);
        chk("st_gnt_stall", 32'(stall_o), 32'd0);
        @(negedge clk_i);
        dmem_gnt_i = 1'b0;
        #1;
        chk("st_req_drop", 32'(dmem_req_o), 32'd0);
        chk("st_after_stall", 32'(stall_o), 32'd0);
        chk("st_wben", 32'(wbEnable_o), 32'd0);
        @(negedge clk_i);
        chk("st_wben_later", 32'(wbEnable_o), 32'd0);

        // Display latch, hold, and ignore while stalled
        idle_inputs();
        displayEn_i = 1'b1; data_i = 32'd42;
        @(negedge clk_i);
        idle_inputs();
        chk("disp_latch", disp_o, 32'd42);
        @(negedge clk_i);
        chk("disp_hold", disp_o, 32'd42);
        mem(1'b0, 11'h003, 32'h0, 5'd12, 1'b1);
        displayEn_i = 1'b1; data_i = 32'd99;
        exp_q.push_back('{d: 32'hCAFE_F00D, a: 5'd12});
        @(negedge clk_i);
        idle_inputs();
        displayEn_i = 1'b1; data_i = 32'd77; dmem_gnt_i = 1'b1;
        #1 chk("disp_ld_stall", 32'(stall_o), 32'd1);
        @(negedge clk_i);
        chk("disp_stalled", disp_o, 32'd42);
        idle_inputs();
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFE_F00D;
        @(negedge clk_i);
        idle_inputs();
        chk("disp_after_ld", disp_o, 32'd42);
        @(negedge clk_i);

        // Reset during RESP; the late rvalid must not write back
        mem(1'b0, 11'h055, 32'h0, 5'd7, 1'b1);
        @(negedge clk_i);
        idle_inputs();
        dmem_gnt_i = 1'b1;
        @(negedge clk_i);
        dmem_gnt_i = 1'b0;
        #1 chk("rst_resp_stall_pre", 32'(stall_o), 32'd1);
        #1 reset_i = 1'b1;
        #1;
        chk("midrst_req", 32'(dmem_req_o), 32'd0);
        chk("midrst_stall", 32'(stall_o), 32'd0);
        chk("midrst_wben", 32'(wbEnable_o), 32'd0);
        @(negedge clk_i);
        reset_i = 1'b0;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1234_5678;
        #1 chk("late_rvalid_stall", 32'(stall_o), 32'd0);
        @(negedge clk_i);
        idle_inputs();
        chk("late_rvalid_wben", 32'(wbEnable_o), 32'd0);
        @(negedge clk_i);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
